// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERROR    = 2'd2
  } ctrl_state_e;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // Pipeline register load enables, grouped so stall decode can set them together.
  typedef struct packed {
    logic pc;
    logic if_id;
    logic id_ex;
    logic ex_mem;
    logic mem_wb;
  } stage_en_t;

  // A later stage can supply src only if it really writes a non-zero register equal to src.
  function automatic logic reg_hit(input logic [4:0] waddr, input logic wena,
                                   input logic [4:0] src);
    return wena && (waddr != REG_ZERO) && (waddr == src);
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_forward_unit.sv
// Operand forwarding select for one EX-stage source; EX/MEM beats MEM/WB.
module forward_unit
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] ex_src,
  input  logic [4:0] mem_waddr,
  input  logic       mem_wena,
  input  logic [4:0] wb_waddr,
  input  logic       wb_wena,
  output logic [1:0] sel
);

  // Youngest producer wins: EX/MEM result is newer than MEM/WB.
  always_comb begin
    sel = FWD_RF;
    if (reg_hit(mem_waddr, mem_wena, ex_src))
      sel = FWD_EXMEM;
    else if (reg_hit(wb_waddr, wb_wena, ex_src))
      sel = FWD_MEMWB;
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/forwarding controller for the five-stage pipeline with
// multi-cycle data-memory wait sequencing and timeout detection.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [4:0]  id_rs_addr_i,
  input  logic [4:0]  id_rt_addr_i,
  input  logic        id_rs_used_i,
  input  logic        id_rt_used_i,
  input  logic [4:0]  ex_rs_addr_i,
  input  logic [4:0]  ex_rt_addr_i,
  input  logic [4:0]  ex_rd_waddr_i,
  input  logic        ex_rd_wena_i,
  input  logic        ex_is_load_i,
  input  logic [4:0]  mem_rd_waddr_i,
  input  logic        mem_rd_wena_i,
  input  logic [4:0]  wb_rd_waddr_i,
  input  logic        wb_rd_wena_i,
  input  logic        ex_branch_taken_i,
  input  logic        dmem_req_i,
  input  logic        dmem_ready_i,
  output logic        pc_en_o,
  output logic        if_id_en_o,
  output logic        id_ex_en_o,
  output logic        ex_mem_en_o,
  output logic        mem_wb_en_o,
  output logic        if_id_flush_o,
  output logic        id_ex_flush_o,
  output logic        mem_wb_bubble_o,
  output logic [1:0]  fwd_a_sel_o,
  output logic [1:0]  fwd_b_sel_o,
  output logic        mem_timeout_o,
  output logic [15:0] stall_count_o
);

  localparam int CNT_W = (MEM_WAIT_MAX > 2) ? $clog2(MEM_WAIT_MAX) : 1;
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MEM_WAIT_MAX - 1);

  ctrl_state_e      state, state_nxt;
  logic [CNT_W-1:0] wait_cnt, wait_cnt_nxt;
  logic [15:0]      stall_cnt;

  stage_en_t en;
  logic      if_id_flush, id_ex_flush, mem_wb_bubble, timeout;
  logic      mem_stall, decode_hazards, load_use;
  logic [1:0] fwd_a, fwd_b;

  // Load-use: a load in EX writes a register the ID instruction is about to read.
  always_comb begin
    load_use = ex_is_load_i && ex_rd_wena_i && (ex_rd_waddr_i != REG_ZERO) &&
               (((ex_rd_waddr_i == id_rs_addr_i) && id_rs_used_i) ||
                ((ex_rd_waddr_i == id_rt_addr_i) && id_rt_used_i));
  end

  // Next-state and Mealy decode of enables, flushes and bubble.
  always_comb begin
    state_nxt      = state;
    wait_cnt_nxt   = wait_cnt;
    en             = '{default: 1'b1};
    if_id_flush    = 1'b0;
    id_ex_flush    = 1'b0;
    mem_wb_bubble  = 1'b0;
    timeout        = 1'b0;
    mem_stall      = 1'b0;
    decode_hazards = 1'b0;

    case (state)
      ST_RUN: begin
        if (dmem_req_i && !dmem_ready_i) begin
          mem_stall    = 1'b1;
          state_nxt    = ST_MEM_WAIT;
          wait_cnt_nxt = '0;
        end else begin
          decode_hazards = 1'b1;
        end
      end
      ST_MEM_WAIT: begin
        if (!dmem_ready_i) begin
          mem_stall = 1'b1;
          if (wait_cnt == WAIT_LAST)
            state_nxt = ST_ERROR;
          else
            wait_cnt_nxt = wait_cnt + 1'b1;
        end else begin
          // Exit cycle: a branch held in EX during the wait flushes now.
          decode_hazards = 1'b1;
          state_nxt      = ST_RUN;
        end
      end
      ST_ERROR: begin
        en      = '0;
        timeout = 1'b1;
      end
      default: state_nxt = ST_RUN;
    endcase

    // Freeze everything up to EX/MEM; MEM/WB drains with a bubble.
    if (mem_stall) begin
      en.pc         = 1'b0;
      en.if_id      = 1'b0;
      en.id_ex      = 1'b0;
      en.ex_mem     = 1'b0;
      mem_wb_bubble = 1'b1;
    end

    // A taken branch squashes the ID instruction, so its load-use stall is moot.
    if (decode_hazards) begin
      if (ex_branch_taken_i) begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (load_use) begin
        en.pc       = 1'b0;
        en.if_id    = 1'b0;
        id_ex_flush = 1'b1;
      end
    end
  end

  // State register and memory-wait counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= ST_RUN;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  // Saturating count of PC-stalled cycles; ERROR cycles are not stalls.
  always_ff @(posedge clk_i) begin
    if (rst_i)
      stall_cnt <= '0;
    else if ((state != ST_ERROR) && !en.pc && (stall_cnt != 16'hFFFF))
      stall_cnt <= stall_cnt + 16'd1;
  end

  forward_unit u_fwd_a (
    .ex_src    (ex_rs_addr_i),
    .mem_waddr (mem_rd_waddr_i),
    .mem_wena  (mem_rd_wena_i),
    .wb_waddr  (wb_rd_waddr_i),
    .wb_wena   (wb_rd_wena_i),
    .sel       (fwd_a)
  );

  forward_unit u_fwd_b (
    .ex_src    (ex_rt_addr_i),
    .mem_waddr (mem_rd_waddr_i),
    .mem_wena  (mem_rd_wena_i),
    .wb_waddr  (wb_rd_waddr_i),
    .wb_wena   (wb_rd_wena_i),
    .sel       (fwd_b)
  );

  // Reset forces every control output quiet, including the registered counter view.
  always_comb begin
    pc_en_o         = !rst_i && en.pc;
    if_id_en_o      = !rst_i && en.if_id;
    id_ex_en_o      = !rst_i && en.id_ex;
    ex_mem_en_o     = !rst_i && en.ex_mem;
    mem_wb_en_o     = !rst_i && en.mem_wb;
    if_id_flush_o   = !rst_i && if_id_flush;
    id_ex_flush_o   = !rst_i && id_ex_flush;
    mem_wb_bubble_o = !rst_i && mem_wb_bubble;
    mem_timeout_o   = !rst_i && timeout;
    fwd_a_sel_o     = rst_i ? FWD_RF : fwd_a;
    fwd_b_sel_o     = rst_i ? FWD_RF : fwd_b;
    stall_count_o   = rst_i ? 16'd0 : stall_cnt;
  end

endmodule
